register_file_sb: RTL

Parametrised successor of the core's integer register file, for the pipelined core. Keeps combinational read, synchronous write, hardwired x0 and stack-pointer initialisation. Adds three things:
- write-to-read bypass;
- synchronous reset to architectural init values;
- per-register pending-write scoreboard (saturating counters) so decode can detect RAW hazards with multiple in-flight producers.

---
 rtl/register_file_sb.sv | 114 +++++++++++
 1 files changed

// File: rtl/register_file_sb.sv
// Integer register file for the pipelined core: combinational reads with writeback bypass,
// synchronous writes, hardwired x0, and a per-register pending-write scoreboard for RAW detection.
module register_file_sb #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              AW       = 5,
    parameter int              SP_INDEX = 2,
    parameter logic [XLEN-1:0] SP_INIT  = 32'h010F_4240,
    parameter int              CNT_W    = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   addr_rs1,
    input  logic [AW-1:0]   addr_rs2,
    output logic [XLEN-1:0] data_rs1,
    output logic [XLEN-1:0] data_rs2,
    output logic            busy_rs1,
    output logic            busy_rs2,
    input  logic            write_enable,
    input  logic [AW-1:0]   addr_rd,
    input  logic [XLEN-1:0] data_rd,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            sb_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // x0 has no storage; index 0 never matches the loops below, so it reads 0 and ignores writes/issues.
    logic [XLEN-1:0]  regs     [1:NREGS-1];
    logic [CNT_W-1:0] cnt      [1:NREGS-1];
    logic [CNT_W-1:0] cnt_next [1:NREGS-1];
    logic             overflow_hit;

    logic dec_rs1;
    logic dec_rs2;

    assign dec_rs1 = write_enable && (addr_rd == addr_rs1);
    assign dec_rs2 = write_enable && (addr_rd == addr_rs2);

    // Out-of-range and zero addresses fall through to the defaults: data 0, not busy.
    always_comb begin
        data_rs1 = '0;
        data_rs2 = '0;
        busy_rs1 = 1'b0;
        busy_rs2 = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (addr_rs1 == AW'(i)) begin
                data_rs1 = dec_rs1 ? data_rd : regs[i];
                busy_rs1 = (cnt[i] > CNT_ONE) || ((cnt[i] == CNT_ONE) && !dec_rs1);
            end
            if (addr_rs2 == AW'(i)) begin
                data_rs2 = dec_rs2 ? data_rd : regs[i];
                busy_rs2 = (cnt[i] > CNT_ONE) || ((cnt[i] == CNT_ONE) && !dec_rs2);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (write_enable && (addr_rd == AW'(i))) begin
                    regs[i] <= data_rd;
                end
            end
        end
    end

    // A simultaneous issue and writeback to the same register cancel out.
    always_comb begin
        overflow_hit = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            cnt_next[i] = cnt[i];
            if (issue_valid && (issue_rd == AW'(i)) && !(write_enable && (addr_rd == AW'(i)))) begin
                if (cnt[i] == CNT_MAX) begin
                    overflow_hit = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end else if (write_enable && (addr_rd == AW'(i)) && !(issue_valid && (issue_rd == AW'(i)))) begin
                if (cnt[i] != '0) begin
                    cnt_next[i] = cnt[i] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                cnt[i] <= '0;
            end
            sb_overflow <= 1'b0;
        end else if (flush) begin
            for (int i = 1; i < NREGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (overflow_hit) begin
                sb_overflow <= 1'b1;
            end
        end
    end

endmodule
